// File: rtl/xserial_pkg.sv
// xserial_pkg: shared definitions for the XSerial transmit path.
//   FRAME_W               frame width in bits (fixed by the protocol)
//   DEST/KIND/PAYLOAD_LSB bit positions of the frame fields
//   KIND_*                frame kind codes
//   tx_state_e            serializer FSM states
//   flow_frame()          builds a HALT/RESUME flow message frame
//   is_data_frame()       true when a frame carries the data kind
package xserial_pkg;

    localparam int FRAME_W     = 12;

    localparam int DEST_LSB    = 0;
    localparam int KIND_LSB    = 2;
    localparam int PAYLOAD_LSB = 4;

    localparam logic [1:0] KIND_DATA   = 2'b00;
    localparam logic [1:0] KIND_HALT   = 2'b01;
    localparam logic [1:0] KIND_RESUME = 2'b10;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_GAP    = 3'd5
    } tx_state_e;

    // Flow messages carry no destination and no payload, only the kind.
    function automatic logic [FRAME_W-1:0] flow_frame(input logic halt);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[DEST_LSB +: 2]    = 2'b00;
        f[KIND_LSB +: 2]    = halt ? KIND_HALT : KIND_RESUME;
        f[PAYLOAD_LSB +: 8] = 8'h00;
        return f;
    endfunction

    function automatic logic is_data_frame(input logic [FRAME_W-1:0] f);
        return f[KIND_LSB +: 2] == KIND_DATA;
    endfunction

endpackage

// File: rtl/xserial_tx_serializer.sv
// xserial_tx_serializer: sends 12-bit XSerial frames on a single-bit line.
// Line format per frame: start 0, 12 data bits LSB first, optional even
// parity bit, stop 1, then GAP_CYCLES idle-high bits.
// Ports:
//   clock, reset          clock (one bit per cycle), async active-high reset
//   in_data/in_valid/in_ack       data frame from the output FIFO
//   flow_req/flow_halt/flow_ack   HALT/RESUME flow message request
//   halt_req              peer asked us to stop sending data frames
//   halted                data frames currently blocked
//   busy                  frame occupying the line
//   out_data              serial line, idles high
//   dbg_state             current FSM state, for observation only
//
// Handshake: a requester holds its request (in_valid or flow_req) level
// until it sees the matching one-cycle ack. Requests are only evaluated in
// IDLE; the ack is registered, so it is high during the cycle after the
// deciding edge, the frame is already captured by then, and the start bit
// follows in the next cycle. A request dropped before its ack is ignored.
module xserial_tx_serializer
    import xserial_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ack,
    input  logic               halt_req,
    input  logic               flow_req,
    input  logic               flow_halt,
    output logic               flow_ack,
    output logic               halted,
    output logic               busy,
    output logic               out_data,
    output tx_state_e          dbg_state
);

    localparam logic [3:0] LAST_BIT   = 4'(FRAME_W - 1);
    localparam logic [3:0] GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam tx_state_e  AFTER_DATA = PARITY_EN ? TX_PARITY : TX_STOP;
    localparam tx_state_e  AFTER_STOP = (GAP_CYCLES > 0) ? TX_GAP : TX_IDLE;

    tx_state_e          state_q;
    logic [FRAME_W-1:0] shift_q;
    logic               parity_q;
    logic [3:0]         bit_cnt_q;
    logic [3:0]         gap_cnt_q;
    logic               out_q;
    logic               in_ack_q;
    logic               flow_ack_q;
    logic               halted_q;
    logic               busy_q;

    logic [FRAME_W-1:0] flow_frame_d;
    assign flow_frame_d = flow_frame(flow_halt);

    // Each state decides the line bit for the following cycle, so out_data
    // always comes straight from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            out_q      <= 1'b1;
            in_ack_q   <= 1'b0;
            flow_ack_q <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            in_ack_q   <= 1'b0;
            flow_ack_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    out_q    <= 1'b1;
                    busy_q   <= 1'b0;
                    halted_q <= halt_req;
                    // Data is gated by the halted value taken this cycle, so a
                    // halt raised during the previous frame blocks the very
                    // first IDLE decision after it.
                    if (flow_req) begin
                        flow_ack_q <= 1'b1;
                        shift_q    <= flow_frame_d;
                        parity_q   <= ^flow_frame_d;
                        state_q    <= TX_START;
                    end else if (in_valid && !halt_req) begin
                        in_ack_q <= 1'b1;
                        shift_q  <= in_data;
                        parity_q <= ^in_data;
                        state_q  <= TX_START;
                    end
                end
                TX_START: begin
                    out_q     <= 1'b0;
                    busy_q    <= 1'b1;
                    bit_cnt_q <= '0;
                    state_q   <= TX_DATA;
                end
                TX_DATA: begin
                    out_q     <= shift_q[0];
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= AFTER_DATA;
                    end
                end
                TX_PARITY: begin
                    out_q   <= parity_q;
                    state_q <= TX_STOP;
                end
                TX_STOP: begin
                    out_q     <= 1'b1;
                    gap_cnt_q <= '0;
                    state_q   <= AFTER_STOP;
                end
                TX_GAP: begin
                    out_q     <= 1'b1;
                    gap_cnt_q <= gap_cnt_q + 4'd1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= TX_IDLE;
                    end
                end
                default: begin
                    out_q   <= 1'b1;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign in_ack    = in_ack_q;
    assign flow_ack  = flow_ack_q;
    assign halted    = halted_q;
    assign busy      = busy_q;
    assign out_data  = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_xserial_tx_serializer.sv
`timescale 1ns/1ps
module tb_xserial_tx_serializer;
    import xserial_pkg::*;

    localparam int GAP     = 1;
    localparam bit PE      = 1'b1;
    localparam int PERIOD  = 1 + 1 + 12 + 1 + 1 + 1;  // ack to next ack, defaults
    localparam int PERIOD2 = 1 + 1 + 12 + 0 + 1 + 0;  // no parity, no gap

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT with default parameters ----------------
    logic [11:0] in_data   = '0;
    logic        in_valid  = 1'b0;
    logic        halt_req  = 1'b0;
    logic        flow_req  = 1'b0;
    logic        flow_halt = 1'b0;
    logic        in_ack, flow_ack, halted, busy, out_data;
    tx_state_e   dbg_state;

    xserial_tx_serializer #(.GAP_CYCLES(GAP), .PARITY_EN(PE)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
        .halt_req(halt_req), .flow_req(flow_req), .flow_halt(flow_halt),
        .flow_ack(flow_ack), .halted(halted), .busy(busy),
        .out_data(out_data), .dbg_state(dbg_state)
    );

    // ---------------- DUT without parity and gap ----------------
    logic [11:0] in_data2  = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ack2, flow_ack2, halted2, busy2, out_data2;
    tx_state_e   dbg_state2;

    xserial_tx_serializer #(.GAP_CYCLES(0), .PARITY_EN(1'b0)) dut2 (
        .clock(clock), .reset(reset),
        .in_data(in_data2), .in_valid(in_valid2), .in_ack(in_ack2),
        .halt_req(1'b0), .flow_req(1'b0), .flow_halt(1'b0),
        .flow_ack(flow_ack2), .halted(halted2), .busy(busy2),
        .out_data(out_data2), .dbg_state(dbg_state2)
    );

    logic hist2 [0:1023];
    always @(negedge clock) hist2[cyc[9:0]] <= out_data2;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];       // expected frames, in send order
    bit          exp_kind_q[$];  // 1 = flow message, 0 = data frame
    logic        line_q[$];      // expected line bits of the frame in flight
    int          last_ack = 0;
    bit          have_last = 1'b0;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_eq(input string name, input int act, input int req);
        chk(name, act == req, act, req);
    endtask

    // Reference line image of one frame: bit i is the line value i cycles
    // after the start bit.
    function automatic logic [31:0] line_bits(input logic [11:0] f, input bit pe,
                                              input int gap, output int len);
        logic [31:0] v;
        int n;
        v = '1;
        v[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 12; i++) begin
            v[n] = f[i];
            n++;
        end
        if (pe) begin
            v[n] = ($countones(f) % 2) == 1;
            n++;
        end
        v[n] = 1'b1;
        n = n + 1 + gap;
        len = n;
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic        b;
        logic [31:0] v;
        int          n;
        logic [11:0] f;
        bit          k;
        if (reset) begin
            line_q.delete();
            have_last = 1'b0;
            chk_eq("reset_in_ack", in_ack, 0);
            chk_eq("reset_flow_ack", flow_ack, 0);
        end else if (line_q.size() > 0) begin
            b = line_q.pop_front();
            chk_eq("line_bit", out_data, b);
            chk_eq("busy_in_frame", busy, 1);
            chk_eq("ack_in_frame", in_ack | flow_ack, 0);
        end else begin
            chk_eq("idle_line", out_data, 1);
            chk_eq("idle_busy", busy, 0);
            if (in_ack || flow_ack) begin
                chk_eq("one_ack_only", in_ack & flow_ack, 0);
                if (exp_kind_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual in_ack=%0d flow_ack=%0d required=none (cycle %0d)",
                             in_ack, flow_ack, cyc);
                end else begin
                    k = exp_kind_q.pop_front();
                    f = exp_q.pop_front();
                    chk_eq("ack_kind_flow", flow_ack, k);
                    v = line_bits(f, PE, GAP, n);
                    for (int i = 0; i < n; i++) line_q.push_back(v[i]);
                end
                if (have_last) chk("ack_spacing", (cyc - last_ack) >= PERIOD, cyc - last_ack, PERIOD);
                have_last = 1'b1;
                last_ack  = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // which: 0 = in_ack, 1 = flow_ack, 2 = in_ack2
    task automatic wait_ack(input int which, input string name, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((which == 0 && in_ack) || (which == 1 && flow_ack) || (which == 2 && in_ack2)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=timeout required=ack", name);
        end
    endtask

    task automatic send_data(input logic [11:0] f, output int at);
        in_data = f;
        exp_q.push_back(f);
        exp_kind_q.push_back(1'b0);
        in_valid = 1'b1;
        wait_ack(0, "data_ack", at);
        in_valid = 1'b0;
        in_data  = 12'($urandom);
    endtask

    task automatic send_flow(input logic h);
        int at;
        flow_halt = h;
        exp_q.push_back({8'h00, (h ? 2'b01 : 2'b10), 2'b00});
        exp_kind_q.push_back(1'b1);
        flow_req = 1'b1;
        wait_ack(1, "flow_ack", at);
        flow_req  = 1'b0;
        flow_halt = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          t1, t2, n;
        logic [31:0] v;

        repeat (3) @(negedge clock);
        chk_eq("rst_out_data", out_data, 1);
        chk_eq("rst_halted", halted, 0);
        chk_eq("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Back-to-back frames without parity and gap.
        in_data2  = 12'hFFF;
        in_valid2 = 1'b1;
        wait_ack(2, "b2b_ack0", t1);
        in_data2 = 12'h000;
        wait_ack(2, "b2b_ack1", t2);
        in_valid2 = 1'b0;
        chk_eq("b2b_spacing", t2 - t1, PERIOD2);
        repeat (20) @(negedge clock);
        v = line_bits(12'hFFF, 1'b0, 0, n);
        for (int i = 0; i < n; i++) chk_eq("b2b_line_a", hist2[10'(t1 + 1 + i)], v[i]);
        chk_eq("b2b_ack_idle", hist2[10'(t1 + n + 1)], 1);
        v = line_bits(12'h000, 1'b0, 0, n);
        for (int i = 0; i < n; i++) chk_eq("b2b_line_b", hist2[10'(t1 + PERIOD2 + 1 + i)], v[i]);

        // Data frame 12'hA53, then an immediately pending second frame.
        send_data(12'hA53, t1);
        send_data(12'h1E7, t2);
        chk_eq("a53_next_ack", t2 - t1, PERIOD);
        repeat (PERIOD + 2) @(negedge clock);

        // Flow message beats a simultaneous data frame.
        flow_halt = 1'b1;
        flow_req  = 1'b1;
        in_data   = 12'h3C5;
        in_valid  = 1'b1;
        exp_q.push_back(12'h004);
        exp_kind_q.push_back(1'b1);
        exp_q.push_back(12'h3C5);
        exp_kind_q.push_back(1'b0);
        wait_ack(1, "prio_flow_ack", t1);
        chk_eq("prio_in_ack_low", in_ack, 0);
        flow_req = 1'b0;
        wait_ack(0, "prio_data_ack", t2);
        in_valid = 1'b0;
        chk_eq("prio_spacing", t2 - t1, PERIOD);
        repeat (PERIOD + 2) @(negedge clock);

        // Halt raised mid-frame: frame completes, data blocked, RESUME still sent.
        send_data(12'h5A1, t1);
        in_data  = 12'h0B7;
        in_valid = 1'b1;
        repeat (5) @(negedge clock);
        halt_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            chk_eq("halt_no_in_ack", in_ack, 0);
        end
        chk_eq("halted_set", halted, 1);
        send_flow(1'b0);
        halt_req = 1'b0;
        exp_q.push_back(12'h0B7);
        exp_kind_q.push_back(1'b0);
        wait_ack(0, "resume_data_ack", t2);
        in_valid = 1'b0;
        chk_eq("halted_clear", halted, 0);
        repeat (PERIOD + 2) @(negedge clock);

        // Flow request withdrawn while a data frame is in flight.
        send_data(12'h9E2, t1);
        repeat (3) @(negedge clock);
        flow_halt = 1'b1;
        flow_req  = 1'b1;
        repeat (6) @(negedge clock);
        flow_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk_eq("withdrawn_flow_ack", flow_ack, 0);
        end

        // Reset at data bit 6 of a frame.
        send_data(12'hC3A, t1);
        repeat (7) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_eq("rst_mid_out_data", out_data, 1);
        chk_eq("rst_mid_busy", busy, 0);
        in_data  = 12'h6D1;
        in_valid = 1'b1;
        repeat (3) @(negedge clock);
        exp_q.push_back(12'h6D1);
        exp_kind_q.push_back(1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk_eq("post_reset_ack", in_ack, 1);
        in_valid = 1'b0;
        repeat (PERIOD + 2) @(negedge clock);

        // Randomized mix of data frames and flow messages.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) send_flow(1'($urandom_range(0, 1)));
            else send_data(12'($urandom), t1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (PERIOD + 4) @(negedge clock);
        chk_eq("exp_q_drained", exp_q.size(), 0);
        chk_eq("line_drained", line_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
